// File: rtl/sub_byte_seq.sv
// rtl/sub_byte_seq.sv - Iterative AES SubBytes engine, LANES S-box lookups per cycle.
// Optional SUB_BYTE_INV_EN adds an inv input selecting the inverse S-box.
module sub_byte_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
`ifdef SUB_BYTE_INV_EN
    input  logic         inv,
`endif
    output logic         busy
);

    localparam int GROUPS = 16 / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("sub_byte_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Row-major table: entry x lives at bits [8x : 8x+7].
    localparam logic [0:2047] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX_FWD[{x, 3'b000} +: 8];
    endfunction

`ifdef SUB_BYTE_INV_EN
    localparam logic [0:2047] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return SBOX_INV[{x, 3'b000} +: 8];
    endfunction

    logic inv_q;
`endif

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [0:127]       data_q;
    logic [0:127]       data_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [3:0]         grp_base;
    logic [3:0]         lane_byte [LANES];
    logic [7:0]         lane_in   [LANES];
    logic [7:0]         lane_out  [LANES];

    assign grp_base = 4'(int'(cnt_q) * LANES);

    // One independent table read port per lane.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_byte[l] = grp_base + 4'(l);
        assign lane_in[l]   = data_q[{lane_byte[l], 3'b000} +: 8];
`ifdef SUB_BYTE_INV_EN
        assign lane_out[l]  = inv_q ? sbox_inv(lane_in[l]) : sbox_fwd(lane_in[l]);
`else
        assign lane_out[l]  = sbox_fwd(lane_in[l]);
`endif
    end

    always_comb begin
        data_d = data_q;
        for (int l = 0; l < LANES; l++) begin
            data_d[{lane_byte[l], 3'b000} +: 8] = lane_out[l];
        end
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SUB_BYTE_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_state;
                        cnt_q      <= '0;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef SUB_BYTE_INV_EN
                        inv_q      <= inv;
`endif
                    end
                end
                BUSY: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = data_q;

endmodule

// File: tb/tb_sub_byte_seq.sv
// tb/tb_sub_byte_seq.sv - Scoreboard bench for sub_byte_seq at LANES=1, 4 and 16.
module tb_sub_byte_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam int LANES_OF [3] = '{1, 4, 16};

    logic         reset;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [0:127] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [0:127] out_state [3];
    logic         busy      [3];
`ifdef SUB_BYTE_INV_EN
    logic         inv       [3];
    logic         inv_drv;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   fwd_tbl [256];
    logic [7:0]   inv_tbl [256];
    logic [0:127] exp_q [$];

    sub_byte_seq #(.LANES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]),
`ifdef SUB_BYTE_INV_EN
        .inv(inv[0]),
`endif
        .busy(busy[0])
    );

    sub_byte_seq #(.LANES(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]),
`ifdef SUB_BYTE_INV_EN
        .inv(inv[1]),
`endif
        .busy(busy[1])
    );

    sub_byte_seq #(.LANES(16)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_state(in_state[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_state(out_state[2]),
`ifdef SUB_BYTE_INV_EN
        .inv(inv[2]),
`endif
        .busy(busy[2])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Reference S-box built from the GF(2^8) inverse followed by the affine map.
    task automatic build_tables();
        logic [7:0] b;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            fwd_tbl[x] = s;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [0:127] model(input logic [0:127] st, input logic iv);
        logic [0:127] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = iv ? inv_tbl[st[8*i +: 8]] : fwd_tbl[st[8*i +: 8]];
        end
        return r;
    endfunction

    task automatic wait_out(input int k, input string tag);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid[k] && lat < 100);
        check({tag, "/lat"}, 128'(lat), 128'(16 / LANES_OF[k]));
    endtask

    task automatic pop_check(input int k, input string tag);
        logic [0:127] e;
        e = exp_q.pop_front();
        check({tag, "/data"}, out_state[k], e);
    endtask

    task automatic release_out(input int k, input string tag);
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
        check({tag, "/idle_rdy"}, 128'(in_ready[k]), 128'(1));
        check({tag, "/idle_vld"}, 128'(out_valid[k]), 128'(0));
    endtask

    task automatic run_block(input int k, input logic [0:127] st, input logic [0:127] exp,
                             input int hold, input string tag);
        int w;
        w = 0;
        while (!in_ready[k] && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check({tag, "/in_rdy"}, 128'(in_ready[k]), 128'(1));
        exp_q.push_back(exp);
        in_state[k] = st;
        in_valid[k] = 1'b1;
`ifdef SUB_BYTE_INV_EN
        inv[k] = inv_drv;
`endif
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        wait_out(k, tag);
        for (int c = 0; c < hold; c++) begin
            check({tag, "/hold_vld"}, 128'(out_valid[k]), 128'(1));
            check({tag, "/hold_data"}, out_state[k], exp_q[0]);
            check({tag, "/hold_rdy"}, 128'(in_ready[k]), 128'(0));
            @(posedge clk);
            #1;
        end
        pop_check(k, tag);
        check({tag, "/busy"}, 128'(busy[k]), 128'(0));
        release_out(k, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        build_tables();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            out_ready[k] = 1'b0;
`ifdef SUB_BYTE_INV_EN
            inv[k]       = 1'b0;
`endif
        end
`ifdef SUB_BYTE_INV_EN
        inv_drv = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst/out_valid", 128'(out_valid[k]), 128'(0));
            check("rst/busy", 128'(busy[k]), 128'(0));
            check("rst/in_ready", 128'(in_ready[k]), 128'(1));
            check("rst/out_state", out_state[k], 128'h0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_block(1, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h637c777bf26b6fc53001672bfed7ab76, 0, "incr");
        for (int k = 0; k < 3; k++) begin
            run_block(k, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                      128'hd42711aee0bf98f1b8b45de51e415230, 0, "fips");
        end
        run_block(1, {16{8'hff}}, {16{8'h16}}, 10, "bkpr");

        // Second in_valid raised during BUSY must wait for IDLE.
        exp_q.push_back(128'hd42711aee0bf98f1b8b45de51e415230);
        in_state[1] = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        in_state[1] = '0;
        wait_out(1, "ign1");
        check("ign1/in_rdy", 128'(in_ready[1]), 128'(0));
        pop_check(1, "ign1");
        exp_q.push_back({16{8'h63}});
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[1] = 1'b0;
        check("ign2/in_rdy", 128'(in_ready[1]), 128'(1));
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        wait_out(1, "ign2");
        pop_check(1, "ign2");
        release_out(1, "ign2");

        // Asynchronous reset two cycles into BUSY.
        in_state[1] = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("mid/busy", 128'(busy[1]), 128'(1));
        reset = 1'b0;
        #1;
        check("mid/out_valid", 128'(out_valid[1]), 128'(0));
        check("mid/out_state", out_state[1], 128'h0);
        check("mid/in_ready", 128'(in_ready[1]), 128'(1));
        check("mid/busy0", 128'(busy[1]), 128'(0));
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_block(1, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h637c777bf26b6fc53001672bfed7ab76, 0, "post");

        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 3; r++) begin
                logic [0:127] st;
                st = {$urandom, $urandom, $urandom, $urandom};
                run_block(k, st, model(st, 1'b0), r, "rand");
            end
        end

`ifdef SUB_BYTE_INV_EN
        inv_drv = 1'b1;
        run_block(1, {16{8'hed}}, {16{8'h53}}, 0, "inv_ed");
        run_block(1, {16{8'h63}}, {16{8'h00}}, 0, "inv_63");
        for (int k = 0; k < 3; k++) begin
            logic [0:127] st;
            st = {$urandom, $urandom, $urandom, $urandom};
            run_block(k, st, model(st, 1'b1), 0, "inv_rand");
        end
        inv_drv = 1'b0;
        run_block(1, {16{8'h00}}, {16{8'h63}}, 0, "inv_off");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
